// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the fetch front end: widths, encodings, fetch-buffer entry and J-immediate decode.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] jimm(input logic [31:0] instr);
    return {{(XLEN - 20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer: push/pop in the same cycle are both honoured, flush empties it in one cycle.
module fetch_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage is intentionally not reset; the pointers and count alone define which slots are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && !flush_i && full_o));

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, issues one request per cycle to a 1-cycle imem, buffers responses.
// Optional build macro JAL_PREDECODE_EN redirects fetch locally on a pushed JAL.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             issue, push, pop, resp_live;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     push_entry, head_entry;

`ifdef JAL_PREDECODE_EN
  logic            kill_q, kill_d;
  logic            jal_hit;
  logic [XLEN-1:0] jal_target;

  assign resp_live  = inflight_q && !kill_q;
  assign jal_hit    = push && (imem_rdata[6:0] == OPC_JAL);
  assign jal_target = req_pc_q + jimm(imem_rdata);
`else
  assign resp_live  = inflight_q;
`endif

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = resp_live && !redirect_valid;

  // Credit counts the slot freed by this cycle's pop, keeping one request per cycle in steady state.
  assign issue = rst && !redirect_valid && (!fifo_full || pop) &&
                 ((32'(fifo_count) + 32'(inflight_q)) < (FIFO_DEPTH + 32'(pop)));

  assign imem_req   = issue;
  assign imem_addr  = pc_q;
  assign push_entry = '{instr: imem_rdata, pc: req_pc_q};
  assign out_instr  = out_valid ? head_entry.instr : NOP_INSTR;
  assign out_pc     = out_valid ? head_entry.pc    : '0;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (issue) begin
      pc_d     = pc_q + XLEN'(4);
      req_pc_d = pc_q;
    end
`ifdef JAL_PREDECODE_EN
    kill_d = issue && jal_hit;
    if (jal_hit) pc_d = jal_target & ~XLEN'(3);
`endif
    if (redirect_valid) pc_d = redirect_pc & ~XLEN'(3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef JAL_PREDECODE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) kill_q <= 1'b0;
    else      kill_q <= kill_d;
  end
`endif

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: an imem model answers requests, a scoreboard queue holds expected output PCs.
module tb_if_fetch_unit;
  import riscv_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;

  int checks   = 0;
  int failures = 0;
  logic            jal_at_20 = 1'b0;
  logic [XLEN-1:0] exp_q [$];
  logic [XLEN-1:0] mon_pc;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  function automatic logic [31:0] word(input logic [XLEN-1:0] a);
    if (jal_at_20 && a == 32'h20) return 32'h0100_006F;
    return {a[26:2] ^ 25'h15A_5A5A, 7'h13};
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= word(imem_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted output must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: actual pc=%0h required no output", out_pc);
        end else begin
          mon_pc = exp_q.pop_front();
          check("out_pc", out_pc, mon_pc);
          check("out_instr", out_instr, word(mon_pc));
        end
      end else if (!out_valid) begin
        check("idle_instr", out_instr, NOP_INSTR);
        check("idle_pc", out_pc, 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      mid();
      n++;
    end
    check({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic redirect_once(input logic [XLEN-1:0] target);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    mid();
    check("redir_req_off", imem_req, 0);
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_req;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, NOP_INSTR);
    check("rst_pc", out_pc, 0);

    // Streaming from reset, then a redirect while the 0x10 response is in flight.
    foreach (exp_q[i]) exp_q.delete();
    exp_q.push_back(32'h0);   exp_q.push_back(32'h4);   exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);   exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    out_ready = 1'b1;
    rst       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      check("seq_req", imem_req, 1);
      check("seq_addr", imem_addr, 32'(i * 4));
      if (i == 1) check("lat_c1_valid", out_valid, 0);
      if (i == 2) check("lat_c2_valid", out_valid, 1);
      cyc();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    mid();
    check("redir_req_off", imem_req, 0);
    cyc();
    redirect_valid = 1'b0;
    mid();
    check("redir_addr", imem_addr, 32'h100);
    check("redir_req", imem_req, 1);
    drain("redirect");

    // Fill the buffer, then pull reset mid-cycle.
    repeat (4) cyc();
    mid();
    check("full_valid", out_valid, 1);
    check("full_req_off", imem_req, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_req", imem_req, 0);
    check("async_pc", out_pc, 0);
    check("async_instr", out_instr, NOP_INSTR);
    repeat (2) cyc();

    // Decode stalled from reset release: exactly FIFO_DEPTH requests.
    rst   = 1'b1;
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (imem_req) begin
        check("stall_addr", imem_addr, 32'(n_req * 4));
        n_req++;
      end
    end
    check("stall_req_count", n_req, 2);
    check("stall_req_off", imem_req, 0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    cyc();
    out_ready = 1'b1;
    drain("stall");

    // Back-to-back redirects: the later target wins.
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    mid();
    check("b2b_req_off0", imem_req, 0);
    cyc();
    redirect_pc = 32'h300;
    mid();
    check("b2b_req_off1", imem_req, 0);
    cyc();
    redirect_valid = 1'b0;
    mid();
    check("b2b_addr", imem_addr, 32'h300);
    exp_q.push_back(32'h300); exp_q.push_back(32'h304); exp_q.push_back(32'h308);
    cyc();
    out_ready = 1'b1;
    drain("b2b");

    // JAL at 0x20: predecode jumps to 0x30, otherwise 0x24 follows.
    jal_at_20 = 1'b1;
    redirect_once(32'h20);
    exp_q.push_back(32'h20);
`ifdef JAL_PREDECODE_EN
    exp_q.push_back(32'h30); exp_q.push_back(32'h34);
`else
    exp_q.push_back(32'h24); exp_q.push_back(32'h28);
`endif
    out_ready = 1'b1;
    drain("jal");
    jal_at_20 = 1'b0;

    // PC wraps from the top of the address space; low redirect bits are dropped.
    redirect_once(32'hFFFF_FFFE);
    mid();
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cyc();
    mid();
    check("wrap_addr1", imem_addr, 32'h0);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    cyc();
    out_ready = 1'b1;
    drain("wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
